// File: rtl/z80_sram_arbiter_if.sv
// Bus bundle between the tv80n CPU, the video fetcher and the async SRAM pads.
// slave is the arbiter's view; master is the surrounding CPU/video/SRAM side.
interface z80_sram_arbiter_if #(
  parameter int unsigned AW = 16
);
  // CPU side
  logic          cpu_mreq_n;
  logic          cpu_rd_n;
  logic          cpu_wr_n;
  logic          cpu_rfsh_n;
  logic [15:0]   cpu_a;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_di;
  logic          cpu_wait_n;

  // Video fetch side
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [7:0]    vid_data;

  // SRAM pads
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_d_o;
  logic          sram_d_oe;
  logic [7:0]    sram_d_i;
  logic          sram_oe_n;
  logic          sram_we_n;

  modport slave (
    input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_dout,
    output cpu_di, cpu_wait_n,
    input  vid_req, vid_addr,
    output vid_ack, vid_data,
    output sram_a, sram_d_o, sram_d_oe, sram_oe_n, sram_we_n,
    input  sram_d_i
  );

  modport master (
    output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_dout,
    input  cpu_di, cpu_wait_n,
    output vid_req, vid_addr,
    input  vid_ack, vid_data,
    input  sram_a, sram_d_o, sram_d_oe, sram_oe_n, sram_we_n,
    output sram_d_i
  );
endinterface

// File: rtl/z80_sram_arbiter.sv
// Shares one asynchronous 8-bit SRAM between the tv80n CPU bus and a video fetcher.
// Round-robin grant; CPU cycles are stretched with cpu_wait_n until their access completes.
module z80_sram_arbiter #(
  parameter int unsigned AW         = 16,  // SRAM address width, >= 16
  parameter int unsigned ACC_CYCLES = 2    // clk cycles per SRAM access, >= 2
) (
  input  logic              clk,
  input  logic              reset_n,
  z80_sram_arbiter_if.slave bus
);

  localparam int unsigned   CNT_W    = $clog2(ACC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    CPU_WR = 2'd2,
    VID_RD = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             served;
  logic             last_grant_cpu;

  logic             cpu_req;
  logic             cpu_pend;
  logic             cpu_wr_only;
  logic             vid_win;
  logic             cnt_last;
  logic             cpu_done;

  // Refresh cycles never count as requests; rd+wr together is treated as a read.
  assign cpu_req     = !bus.cpu_mreq_n && bus.cpu_rfsh_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);
  assign cpu_pend    = cpu_req && !served;
  assign cpu_wr_only = !bus.cpu_wr_n && bus.cpu_rd_n;

  // vid_ack is still high the cycle after a fetch, before the requester can drop vid_req.
  assign vid_win  = bus.vid_req && !bus.vid_ack && (!cpu_pend || last_grant_cpu);
  assign cnt_last = (cnt == CNT_LAST);
  assign cpu_done = ((state == CPU_RD) || (state == CPU_WR)) && cnt_last;

  // Combinational so the CPU is stalled in the very cycle its request appears.
  assign bus.cpu_wait_n = !cpu_pend;

  // Arbitration FSM with registered SRAM strobes and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      served         <= 1'b0;
      last_grant_cpu <= 1'b0;
      bus.cpu_di     <= 8'h00;
      bus.vid_data   <= 8'h00;
      bus.vid_ack    <= 1'b0;
      bus.sram_a     <= '0;
      bus.sram_d_o   <= 8'h00;
      bus.sram_d_oe  <= 1'b0;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
    end else begin
      bus.vid_ack <= 1'b0;

      // A withdrawn request must not leave a stale served flag behind.
      if (bus.cpu_mreq_n) begin
        served <= 1'b0;
      end else if (cpu_done) begin
        served <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Data stays driven one cycle past the write strobe for hold time.
          bus.sram_d_oe <= 1'b0;
          if (vid_win) begin
            state          <= VID_RD;
            cnt            <= '0;
            last_grant_cpu <= 1'b0;
            bus.sram_a     <= bus.vid_addr;
            bus.sram_oe_n  <= 1'b0;
          end else if (cpu_pend) begin
            cnt            <= '0;
            last_grant_cpu <= 1'b1;
            bus.sram_a     <= AW'(bus.cpu_a);
            if (cpu_wr_only) begin
              state         <= CPU_WR;
              bus.sram_d_o  <= bus.cpu_dout;
              bus.sram_d_oe <= 1'b1;
            end else begin
              state         <= CPU_RD;
              bus.sram_oe_n <= 1'b0;
            end
          end
        end

        CPU_RD, VID_RD: begin
          if (cnt_last) begin
            state         <= IDLE;
            bus.sram_oe_n <= 1'b1;
            if (state == VID_RD) begin
              bus.vid_data <= bus.sram_d_i;
              bus.vid_ack  <= 1'b1;
            end else begin
              bus.cpu_di   <= bus.sram_d_i;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        CPU_WR: begin
          // Strobe stays high for cnt 0 to give address setup before the write.
          if (cnt_last) begin
            state         <= IDLE;
            bus.sram_we_n <= 1'b1;
          end else begin
            cnt           <= cnt + CNT_W'(1);
            bus.sram_we_n <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          bus.sram_oe_n <= 1'b1;
          bus.sram_we_n <= 1'b1;
          bus.sram_d_oe <= 1'b0;
        end
      endcase
    end
  end

  // Pad-level sanity: never fight the SRAM output drivers.
  a_no_oe_we: assert property (@(posedge clk) disable iff (!reset_n)
    !(!bus.sram_oe_n && !bus.sram_we_n));
  a_we_has_data: assert property (@(posedge clk) disable iff (!reset_n)
    !bus.sram_we_n |-> bus.sram_d_oe);
  a_no_oe_with_drive: assert property (@(posedge clk) disable iff (!reset_n)
    !bus.sram_oe_n |-> !bus.sram_d_oe);
  a_ack_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    bus.vid_ack |=> !bus.vid_ack);

endmodule

// File: tb/tb_z80_sram_arbiter.sv
// Directed bench for z80_sram_arbiter against a behavioural async SRAM.
module tb_z80_sram_arbiter;
  localparam int unsigned AW    = 16;
  localparam int unsigned ACC   = 2;
  localparam int          LOG_N = 16;

  logic clk = 1'b0;
  logic reset_n;

  z80_sram_arbiter_if #(.AW(AW)) bus ();

  z80_sram_arbiter #(.AW(AW), .ACC_CYCLES(ACC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Async SRAM model: reads follow the address, writes land while we_n is low.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_req = 1'b0;
  logic [AW-1:0] pre_a   = '0;
  logic [7:0]    pre_d   = 8'h00;

  assign bus.sram_d_i = mem[bus.sram_a];

  always @(negedge clk) begin
    if (pre_req) mem[pre_a] <= pre_d;
    else if (!bus.sram_we_n && bus.sram_d_oe) mem[bus.sram_a] <= bus.sram_d_o;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_req = 1'b1;
    @(negedge clk); #1;
    pre_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_drive(input logic mreq_n, input logic rd_n, input logic wr_n,
                           input logic rfsh_n, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_mreq_n = mreq_n; bus.cpu_rd_n = rd_n; bus.cpu_wr_n = wr_n;
    bus.cpu_rfsh_n = rfsh_n; bus.cpu_a = a; bus.cpu_dout = d;
  endtask

  task automatic cpu_release();
    cpu_drive(1'b1, 1'b1, 1'b1, 1'b1, bus.cpu_a, bus.cpu_dout);
    tick();
  endtask

  // Per-cycle capture; index 0 is the cycle the stimulus was applied.
  logic          we_log  [LOG_N];
  logic          doe_log [LOG_N];
  logic [AW-1:0] a_log   [LOG_N];
  logic [7:0]    d_log   [LOG_N];
  int n_wait_lo, n_oe_lo, n_we_lo, first_ack, first_we_lo;

  task automatic run_log(input int n);
    n_wait_lo = 0; n_oe_lo = 0; n_we_lo = 0; first_ack = -1; first_we_lo = -1;
    for (int i = 0; i < n; i++) begin
      #2;
      we_log[i]  = bus.sram_we_n;
      doe_log[i] = bus.sram_d_oe;
      a_log[i]   = bus.sram_a;
      d_log[i]   = bus.sram_d_o;
      if (!bus.cpu_wait_n) n_wait_lo++;
      if (!bus.sram_oe_n)  n_oe_lo++;
      if (!bus.sram_we_n) begin
        n_we_lo++;
        if (first_we_lo < 0) first_we_lo = i;
      end
      if (bus.vid_ack) begin
        if (first_ack < 0) first_ack = i;
        bus.vid_req = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  logic grant_cpu [8];
  int   n_grant, wlen, wmax;
  logic oe_prev;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0;
    cpu_drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    bus.vid_req = 1'b0; bus.vid_addr = '0;

    poke(16'h0005, 8'h34); poke(16'h000F, 8'h00); poke(16'h0020, 8'h77);
    poke(16'h1234, 8'h5A); poke(16'h0100, 8'hC3); poke(16'h2000, 8'h9E);
    poke(16'h0030, 8'h4B); poke(16'h0050, 8'h00); poke(16'h4000, 8'hE1);

    // Reset values
    check("rst_sram_a",   32'(bus.sram_a), 32'h0);
    check("rst_sram_d_o", 32'(bus.sram_d_o), 32'h0);
    check("rst_d_oe",     32'(bus.sram_d_oe), 32'h0);
    check("rst_oe_n",     32'(bus.sram_oe_n), 32'h1);
    check("rst_we_n",     32'(bus.sram_we_n), 32'h1);
    check("rst_cpu_di",   32'(bus.cpu_di), 32'h0);
    check("rst_vid_data", 32'(bus.vid_data), 32'h0);
    check("rst_vid_ack",  32'(bus.vid_ack), 32'h0);
    check("rst_wait_n",   32'(bus.cpu_wait_n), 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // 1: uncontended CPU read
    cpu_drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 8'h00);
    run_log(6);
    check("t1_wait_clks", n_wait_lo, 3);
    check("t1_oe_clks",   n_oe_lo, 2);
    check("t1_cpu_di",    32'(bus.cpu_di), 32'h34);
    check("t1_wait_held", 32'(bus.cpu_wait_n), 32'h1);
    cpu_release();

    // 2: CPU write, strobe framed by stable address/data
    cpu_drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h000F, 8'hA5);
    run_log(6);
    check("t2_wait_clks", n_wait_lo, 3);
    check("t2_we_clks",   n_we_lo, 1);
    check("t2_we_at",     first_we_lo, 2);
    check("t2_a_before",  32'(a_log[1]), 32'h000F);
    check("t2_a_after",   32'(a_log[3]), 32'h000F);
    check("t2_d_before",  32'(d_log[1]), 32'hA5);
    check("t2_d_after",   32'(d_log[3]), 32'hA5);
    check("t2_doe_hold",  32'(doe_log[3]), 32'h1);
    check("t2_doe_off",   32'(doe_log[4]), 32'h0);
    check("t2_mem",       32'(mem[16'h000F]), 32'hA5);
    cpu_release();

    // 3a: contention after a CPU grant -> video first
    bus.vid_addr = 16'h1234; bus.vid_req = 1'b1;
    cpu_drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 8'h00);
    run_log(8);
    check("t3a_ack_at",   first_ack, 3);
    check("t3a_vid_data", 32'(bus.vid_data), 32'h5A);
    check("t3a_wait_clks", n_wait_lo, 6);
    check("t3a_cpu_di",   32'(bus.cpu_di), 32'h77);
    cpu_release();

    // Solo video fetch leaves last grant on the video side
    bus.vid_addr = 16'h0100; bus.vid_req = 1'b1;
    run_log(5);
    check("tv_ack_at",    first_ack, 3);
    check("tv_vid_data",  32'(bus.vid_data), 32'hC3);
    check("tv_no_wait",   n_wait_lo, 0);
    check("tv_cpu_di_kept", 32'(bus.cpu_di), 32'h77);

    // 3b: contention after a video grant -> CPU first
    bus.vid_addr = 16'h2000; bus.vid_req = 1'b1;
    cpu_drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0030, 8'h00);
    run_log(8);
    check("t3b_wait_clks", n_wait_lo, 3);
    check("t3b_ack_at",   first_ack, 6);
    check("t3b_vid_data", 32'(bus.vid_data), 32'h9E);
    check("t3b_cpu_di",   32'(bus.cpu_di), 32'h4B);
    cpu_release();

    // 4: refresh cycle is ignored
    cpu_drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 8'h00);
    run_log(5);
    check("t4_wait_clks", n_wait_lo, 0);
    check("t4_oe_clks",   n_oe_lo, 0);
    check("t4_we_clks",   n_we_lo, 0);
    cpu_release();

    // 5: continuous video requests vs repeated CPU reads
    bus.vid_addr = 16'h4000; bus.vid_req = 1'b1;
    cpu_drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 8'h00);
    n_grant = 0; wlen = 0; wmax = 0; oe_prev = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (!bus.sram_oe_n && oe_prev && n_grant < 8) begin
        grant_cpu[n_grant] = (bus.sram_a != 16'h4000);
        n_grant++;
      end
      oe_prev = bus.sram_oe_n;
      if (!bus.cpu_wait_n) wlen++;
      else begin
        if (wlen > wmax) wmax = wlen;
        wlen = 0;
      end
      if (bus.cpu_mreq_n) begin
        bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0; bus.cpu_a = bus.cpu_a + 16'd1;
      end else if (bus.cpu_wait_n) begin
        bus.cpu_mreq_n = 1'b1; bus.cpu_rd_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("t5_grants", 32'(n_grant >= 6), 32'h1);
    for (int g = 0; g < 6; g++)
      check($sformatf("t5_grant%0d_is_cpu", g), 32'(grant_cpu[g]), 32'((g % 2) == 0));
    check("t5_wait_le6", 32'(wmax <= 6), 32'h1);
    bus.vid_req = 1'b0;
    cpu_drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    repeat (6) tick();

    // 6: asynchronous reset in the middle of a write strobe
    cpu_drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0050, 8'h66);
    tick();
    tick();
    check("t6_pre_we", 32'(bus.sram_we_n), 32'h0);
    #1 reset_n = 1'b0;
    #1;
    check("t6_we_n",  32'(bus.sram_we_n), 32'h1);
    check("t6_d_oe",  32'(bus.sram_d_oe), 32'h0);
    check("t6_oe_n",  32'(bus.sram_oe_n), 32'h1);
    check("t6_a",     32'(bus.sram_a), 32'h0);
    check("t6_mem_untouched", 32'(mem[16'h0050]), 32'h00);
    tick();
    tick();
    reset_n = 1'b1;
    run_log(6);
    check("t6_wait_clks", n_wait_lo, 3);
    check("t6_we_clks",   n_we_lo, 1);
    check("t6_we_at",     first_we_lo, 2);
    check("t6_mem",       32'(mem[16'h0050]), 32'h66);
    cpu_release();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
